// File: rtl/audio_record_controller.sv
// Record/playback sequencer between command pulses, PDM deserializer, sample RAM and serializer.
// Define LOOP_PLAYBACK_EN to make playback wrap to the first sample instead of stopping.
module audio_record_controller #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              record_start_i,
  input  logic              play_start_i,
  input  logic              stop_i,
  output logic              des_enable_o,
  input  logic              des_done_i,
  input  logic [DATA_W-1:0] des_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ser_enable_o,
  output logic [DATA_W-1:0] ser_data_o,
  input  logic              ser_done_i,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   rec_len_o
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RECORD     = 2'd1,
    ST_PLAY_FETCH = 2'd2,
    ST_PLAY_WAIT  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     rec_len_q, rec_len_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drain_q, drain_d;
  logic                fetch_ph_q, fetch_ph_d;
  logic [DATA_W-1:0]   ser_data_q, ser_data_d;
  logic                full;
  logic                accept;

  assign full   = (rec_len_q == FULL_LEN);
  // drain_q: stop arrived with a sample; stay in RECORD one more cycle so its write lands there
  assign accept = (state_q == ST_RECORD) && des_done_i && !full && !drain_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rec_len_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      drain_q    <= 1'b0;
      fetch_ph_q <= 1'b0;
      ser_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rec_len_q  <= rec_len_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      drain_q    <= drain_d;
      fetch_ph_q <= fetch_ph_d;
      ser_data_q <= ser_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rec_len_d  = rec_len_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    drain_d    = 1'b0;
    fetch_ph_d = 1'b0;
    ser_data_d = ser_data_q;

    if (accept) begin
      we_d      = 1'b1;
      waddr_d   = wr_ptr_q;
      wdata_d   = des_data_i;
      wr_ptr_d  = wr_ptr_q + 1'b1;
      rec_len_d = rec_len_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        ser_data_d = '0;
        if (record_start_i) begin
          state_d   = ST_RECORD;
          wr_ptr_d  = '0;
          rec_len_d = '0;
        end else if (play_start_i && (rec_len_q != '0)) begin
          state_d  = ST_PLAY_FETCH;
          rd_ptr_d = '0;
        end
      end
      ST_RECORD: begin
        // full becomes true on the cycle the final write is presented, so leaving here is safe
        if (full || drain_q) begin
          state_d = ST_IDLE;
        end else if (stop_i) begin
          if (accept) drain_d = 1'b1;
          else        state_d = ST_IDLE;
        end
      end
      ST_PLAY_FETCH: begin
        if (stop_i) begin
          state_d    = ST_IDLE;
          ser_data_d = '0;
        end else if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          ser_data_d = mem_rdata_i;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          state_d    = ST_PLAY_WAIT;
        end
      end
      ST_PLAY_WAIT: begin
        if (stop_i) begin
          state_d    = ST_IDLE;
          ser_data_d = '0;
        end else if (ser_done_i) begin
          if (rd_ptr_q == rec_len_q) begin
`ifdef LOOP_PLAYBACK_EN
            rd_ptr_d = '0;
            state_d  = ST_PLAY_FETCH;
`else
            state_d    = ST_IDLE;
            ser_data_d = '0;
`endif
          end else begin
            state_d = ST_PLAY_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign des_enable_o = (state_q == ST_RECORD) && !full && !drain_q;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = (state_q == ST_PLAY_FETCH) ? rd_ptr_q[ADDR_W-1:0] :
                        (we_q ? waddr_q : '0);
  assign mem_wdata_o  = we_q ? wdata_q : '0;
  assign ser_enable_o = state_q[1];
  assign ser_data_o   = ser_data_q;
  assign state_o      = state_q;
  assign rec_len_o    = rec_len_q;

endmodule

// File: tb/tb_audio_record_controller.sv
// Directed bench for audio_record_controller (ADDR_W=3) with a sample-level model and per-cycle compare.
module tb_audio_record_controller;
  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk, rst;
  logic          record_start, play_start, stop, des_done, ser_done;
  logic [DW-1:0] des_data, mem_rdata, mem_wdata_o, ser_data_o;
  logic          des_enable_o, mem_we_o, ser_enable_o;
  logic [AW-1:0] mem_addr_o;
  logic [1:0]    state_o;
  logic [AW:0]   rec_len_o;

  audio_record_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i(clk), .reset_i(rst),
    .record_start_i(record_start), .play_start_i(play_start), .stop_i(stop),
    .des_enable_o(des_enable_o), .des_done_i(des_done), .des_data_i(des_data),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata),
    .ser_enable_o(ser_enable_o), .ser_data_o(ser_data_o), .ser_done_i(ser_done),
    .state_o(state_o), .rec_len_o(rec_len_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous sample RAM, registered read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata <= ram[mem_addr_o];
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          m_cnt = 0;
  bit          m_rec = 0;
  logic [15:0] m_mem [0:(1<<AW)-1];
  int          play_idx = 0;
  int          wr_seen = 0;
  wr_t         exp_wq[$];
  logic [15:0] presented[$];

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic [1:0] prev;
    wr_t e;
    prev = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 2'd0;
      end else begin
        if (mem_we_o) begin
          wr_seen++;
          check_eq("we_only_in_record", 32'(state_o), 32'd1);
          if (exp_wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", mem_addr_o, mem_wdata_o);
          end else begin
            e = exp_wq.pop_front();
            check_eq("wr_addr", 32'(mem_addr_o), e.addr);
            check_eq("wr_data", 32'(mem_wdata_o), e.data);
          end
        end
        if (state_o == 2'd0) begin
          check_eq("idle_ser_enable", 32'(ser_enable_o), 32'd0);
          check_eq("idle_ser_data", 32'(ser_data_o), 32'd0);
        end
        if (state_o == 2'd3 && prev != 2'd3 && m_cnt != 0) begin
          presented.push_back(ser_data_o);
          check_eq("play_sample", 32'(ser_data_o), 32'(m_mem[play_idx % m_cnt]));
          play_idx++;
        end
        prev = state_o;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_record();
    record_start = 1'b1; tick(); record_start = 1'b0;
    m_rec = 1'b1; m_cnt = 0;
  endtask

  task automatic pulse_play();
    play_start = 1'b1;
    if (m_cnt != 0) play_idx = 0;
    tick(); play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
    m_rec = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] d, input bit with_stop);
    wr_t w;
    des_done = 1'b1; des_data = d; stop = with_stop;
    if (m_rec && m_cnt < (1 << AW)) begin
      w.addr = 32'(m_cnt); w.data = 32'(d);
      exp_wq.push_back(w);
      m_mem[m_cnt] = d;
      m_cnt++;
    end
    tick();
    des_done = 1'b0; stop = 1'b0;
    if (with_stop || m_cnt == (1 << AW)) m_rec = 1'b0;
  endtask

  task automatic pulse_ser_done();
    ser_done = 1'b1; tick(); ser_done = 1'b0;
  endtask

  task automatic wait_state3();
    int n;
    n = 0;
    while (state_o != 2'd3 && n < 20) begin
      tick(); n++;
    end
    check_eq("wait_play_wait", 32'(state_o), 32'd3);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rec = 1'b0; play_idx = 0;
    exp_wq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state_o), 32'd0);
    check_eq({tag, "_rec_len"}, 32'(rec_len_o), 32'd0);
    check_eq({tag, "_des_en"}, 32'(des_enable_o), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
    check_eq({tag, "_ser_en"}, 32'(ser_enable_o), 32'd0);
    check_eq({tag, "_ser_data"}, 32'(ser_data_o), 32'd0);
  endtask

  initial begin
    int wr_base;
    rst = 1'b1;
    record_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    des_done = 1'b0; des_data = '0; ser_done = 1'b0;
    fork
      compare_loop();
    join_none

    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // play with nothing recorded is ignored
    pulse_play(); tick();
    check_eq("play_empty_state", 32'(state_o), 32'd0);

    // record three samples, then stop
    pulse_record();
    check_eq("rec_state", 32'(state_o), 32'd1);
    check_eq("rec_des_en", 32'(des_enable_o), 32'd1);
    pulse_done(16'h1111, 1'b0); tick();
    pulse_done(16'h2222, 1'b0); tick();
    pulse_done(16'h3333, 1'b0); tick(); tick();
    pulse_stop(); tick();
    check_eq("rec3_len", 32'(rec_len_o), 32'd3);
    check_eq("rec3_state", 32'(state_o), 32'd0);
    check_eq("rec3_des_en", 32'(des_enable_o), 32'd0);
    check_eq("rec3_writes", 32'(wr_seen), 32'd3);
    check_eq("rec3_pending", 32'(exp_wq.size()), 32'd0);

    // playback of the three samples
    pulse_play();
    for (int i = 0; i < 3; i++) begin
      wait_state3();
      pulse_ser_done();
    end
`ifdef LOOP_PLAYBACK_EN
    wait_state3();
    pulse_stop();
    check_eq("loop_4th_sample", 32'(presented[3]), 32'h1111);
`endif
    check_eq("play_end_state", 32'(state_o), 32'd0);
    check_eq("play_end_ser_data", 32'(ser_data_o), 32'd0);
    check_eq("play_end_rec_len", 32'(rec_len_o), 32'd3);
    check_eq("play_first", 32'(presented[0]), 32'h1111);
    check_eq("play_second", 32'(presented[1]), 32'h2222);
    check_eq("play_third", 32'(presented[2]), 32'h3333);
    tick();

    // record and play together: record wins; stop with a sample still counts it
    record_start = 1'b1; play_start = 1'b1; tick();
    record_start = 1'b0; play_start = 1'b0;
    m_rec = 1'b1; m_cnt = 0;
    check_eq("rec_wins_state", 32'(state_o), 32'd1);
    pulse_done(16'hAAAA, 1'b1);
    check_eq("stop_done_we", 32'(mem_we_o), 32'd1);
    check_eq("stop_done_des_en", 32'(des_enable_o), 32'd0);
    tick(); tick();
    check_eq("stop_done_state", 32'(state_o), 32'd0);
    check_eq("stop_done_len", 32'(rec_len_o), 32'd1);
    check_eq("stop_done_pending", 32'(exp_wq.size()), 32'd0);

    // record until the RAM is full; the 9th pulse must not be written
    wr_base = wr_seen;
    pulse_record();
    for (int i = 0; i < 9; i++) begin
      pulse_done(16'hB000 + 16'(i), 1'b0);
      tick();
    end
    tick();
    check_eq("full_state", 32'(state_o), 32'd0);
    check_eq("full_len", 32'(rec_len_o), 32'd8);
    check_eq("full_writes", 32'(wr_seen - wr_base), 32'd8);
    check_eq("full_des_en", 32'(des_enable_o), 32'd0);
    check_eq("full_pending", 32'(exp_wq.size()), 32'd0);

    // asynchronous reset during RECORD after two samples
    pulse_record();
    pulse_done(16'h0101, 1'b0); tick();
    pulse_done(16'h0202, 1'b0); tick(); tick();
    check_eq("mid_rec_len", 32'(rec_len_o), 32'd2);
    check_eq("mid_rec_state", 32'(state_o), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_record");
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // asynchronous reset during PLAY_WAIT
    pulse_record();
    pulse_done(16'h5555, 1'b0); tick();
    pulse_done(16'h6666, 1'b0); tick(); tick();
    pulse_stop(); tick();
    pulse_play();
    wait_state3();
    check_eq("mid_play_data", 32'(ser_data_o), 32'h5555);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_play");
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_record_controller.md
Name: audio_record_controller

Overview:
- Top-level sequencer for the audio recorder datapath.
- Record: enables the PDM Deserializer and writes each 16-bit sample (one per done pulse) into a synchronous sample RAM.
- Playback: reads samples back from the RAM in order and hands them one at a time to the output serializer.
- Sits between the user command pulses (button/UART decode) and the Deserializer, RAM and serializer.

Parameters:
- ADDR_W, 17: sample RAM address width; capacity is 2^ADDR_W samples.
- DATA_W, 16: sample width; must match Deserializer data_o.

Ports:
- clock_i  in  1  system clock, 100 MHz
- reset_i  in  1  asynchronous, active-high reset
- record_start_i  in  1  one-cycle command pulse
- play_start_i  in  1  one-cycle command pulse
- stop_i  in  1  one-cycle command pulse
- des_enable_o  out  1  drives Deserializer enable_i
- des_done_i  in  1  Deserializer done_o; one-cycle pulse, sample valid
- des_data_i  in  DATA_W  Deserializer data_o
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data; valid one cycle after the address is driven
- ser_enable_o  out  1  serializer enable
- ser_data_o  out  DATA_W  current playback sample
- ser_done_i  in  1  serializer one-cycle pulse: ser_data_o consumed
- state_o  out  2  IDLE=0, RECORD=1, PLAY_FETCH=2, PLAY_WAIT=3
- rec_len_o  out  ADDR_W+1  number of samples held from the last recording

Behaviour:
- Reset (asynchronous, any state, mid-operation included):
  - state IDLE; wr_ptr, rd_ptr and rec_len_o = 0.
  - All outputs 0: des_enable_o, mem_we_o, mem_addr_o, mem_wdata_o, ser_enable_o, ser_data_o.
- IDLE:
  - record_start_i: go to RECORD; wr_ptr=0; rec_len_o=0; des_enable_o=1 from the next cycle.
  - play_start_i with rec_len_o!=0: go to PLAY_FETCH; rd_ptr=0.
  - play_start_i with rec_len_o==0: ignored.
  - record_start_i and play_start_i in the same cycle: record wins.
  - stop_i in IDLE: no effect.
- RECORD:
  - des_enable_o=1.
  - On des_done_i, the registered write occurs the next cycle: mem_we_o=1 for exactly one cycle, mem_addr_o=wr_ptr, mem_wdata_o=captured des_data_i. wr_ptr and rec_len_o then increment.
  - Full: the write to address 2^ADDR_W-1 completes, rec_len_o=2^ADDR_W, state returns to IDLE, des_enable_o=0. Further des_done_i pulses are ignored.
  - stop_i: go to IDLE, des_enable_o=0 the next cycle.
  - stop_i and des_done_i in the same cycle: that sample is still written and counted.
  - record_start_i and play_start_i: ignored.
- PLAY_FETCH (exactly 2 cycles, ser_enable_o=1):
  - Cycle 1: mem_addr_o=rd_ptr.
  - Cycle 2: mem_rdata_i is captured into ser_data_o at the end of the cycle; rd_ptr++; go to PLAY_WAIT.
- PLAY_WAIT (ser_enable_o=1, ser_data_o held):
  - ser_done_i with rd_ptr==rec_len_o: go to IDLE.
  - ser_done_i otherwise: go to PLAY_FETCH.
- Any PLAY state, stop_i: go to IDLE, ignoring a simultaneous ser_done_i.
- On every IDLE entry: ser_enable_o=0, ser_data_o=0; rec_len_o is retained.
- mem_we_o is never asserted outside RECORD.
- Pointer arithmetic is unsigned. wr_ptr never wraps (the full state ends recording); rd_ptr wraps only under the optional feature.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- Defined: in PLAY_WAIT, ser_done_i with rd_ptr==rec_len_o resets rd_ptr to 0 and goes to PLAY_FETCH. Playback loops until stop_i or reset.
- Undefined: playback ends in IDLE after the last sample, as above.

Test Plan (ADDR_W=3):
- Record then stop: record_start_i, then des_done_i with 0x1111, 0x2222, 0x3333, then stop_i. Required: writes at addr 0/1/2 with those values, mem_we_o one cycle each, rec_len_o=3, state_o=0, des_enable_o=0.
- Record until full: record_start_i, then 9 des_done_i pulses. Required: exactly 8 writes (addr 0..7), auto return to IDLE after the 8th, rec_len_o=8, 9th pulse not written.
- Playback of 3 samples: after the first scenario, play_start_i, then a ser_done_i pulse each time state_o=3. Required: ser_data_o sequence 0x1111, 0x2222, 0x3333; IDLE after the 3rd ser_done_i; ser_data_o=0 afterwards.
  - With LOOP_PLAYBACK_EN: the 4th sample presented is 0x1111.
- Command corner cases:
  - play_start_i with rec_len_o=0: state_o stays 0.
  - record_start_i and play_start_i in the same cycle: state_o=1.
  - stop_i and des_done_i in the same cycle: sample written, rec_len_o incremented.
- Reset mid-operation: assert reset_i during RECORD after 2 samples and during PLAY_WAIT. Required: all outputs 0 and rec_len_o=0 asynchronously, before the next clock edge.
